// File: rtl/scarv_cpu_cop_dispatch.sv
// CPU-side dispatcher for the SCARV coprocessor: issues one instruction, collects
// its response and returns a single registered writeback beat to the CPU pipeline.
module scarv_cpu_cop_dispatch #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [31:0] cpu_insn,
    input  logic [31:0] cpu_rs1_data,
    output logic        cpu_wb_valid,
    input  logic        cpu_wb_ready,
    output logic        cpu_wb_wen,
    output logic [4:0]  cpu_wb_addr,
    output logic [31:0] cpu_wb_data,
    output logic [2:0]  cpu_wb_result,
    output logic        cpu_wb_timeout,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    input  logic        cop_insn_rsp,
    output logic        cpu_insn_ack
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             drain_pending;
    logic             expired;

    assign expired      = (count == CNT_LAST);
    assign cpu_ready    = g_resetn && (state == IDLE);
    assign cpu_insn_ack = (state == WAIT) || (state == DRAIN);

    // The counter saturates on the last budgeted cycle, so an ack landing on that
    // cycle enters WAIT with no budget left instead of wrapping to a fresh count.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state          <= IDLE;
            count          <= '0;
            drain_pending  <= 1'b0;
            cpu_insn_req   <= 1'b0;
            cpu_insn_enc   <= '0;
            cpu_rs1        <= '0;
            cpu_wb_valid   <= 1'b0;
            cpu_wb_wen     <= 1'b0;
            cpu_wb_addr    <= '0;
            cpu_wb_data    <= '0;
            cpu_wb_result  <= '0;
            cpu_wb_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_valid && cpu_ready) begin
                        cpu_insn_enc <= cpu_insn;
                        cpu_rs1      <= cpu_rs1_data;
                        count        <= '0;
                        cpu_insn_req <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cop_insn_ack) begin
                        cpu_insn_req <= 1'b0;
                        state        <= WAIT;
                    end else if (expired) begin
                        cpu_insn_req   <= 1'b0;
                        cpu_wb_valid   <= 1'b1;
                        cpu_wb_timeout <= 1'b1;
                        cpu_wb_wen     <= 1'b0;
                        cpu_wb_addr    <= '0;
                        cpu_wb_data    <= '0;
                        cpu_wb_result  <= 3'b111;
                        state          <= WB;
                    end
                end
                WAIT: begin
                    if (cop_insn_rsp) begin
                        cpu_wb_valid   <= 1'b1;
                        cpu_wb_timeout <= 1'b0;
                        cpu_wb_wen     <= cop_wen && (cop_waddr != 5'd0);
                        cpu_wb_addr    <= cop_waddr;
                        cpu_wb_data    <= cop_wdata;
                        cpu_wb_result  <= cop_result;
                        state          <= WB;
                    end else if (expired) begin
                        // The COP still owes a response; DRAIN swallows it later.
                        drain_pending  <= 1'b1;
                        cpu_wb_valid   <= 1'b1;
                        cpu_wb_timeout <= 1'b1;
                        cpu_wb_wen     <= 1'b0;
                        cpu_wb_addr    <= '0;
                        cpu_wb_data    <= '0;
                        cpu_wb_result  <= 3'b111;
                        state          <= WB;
                    end
                end
                WB: begin
                    if (cpu_wb_ready) begin
                        cpu_wb_valid <= 1'b0;
                        state        <= drain_pending ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (cop_insn_rsp) begin
                        drain_pending <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (((state == ISSUE) || (state == WAIT)) && !expired) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scarv_cpu_cop_dispatch.sv
// Self-checking bench for scarv_cpu_cop_dispatch: directed vector table, random
// transactions against a transaction-level timing model, and reset sequences.
module tb_scarv_cpu_cop_dispatch;

    localparam int T  = 16;
    localparam int CW = 4;

    logic        g_clk;
    logic        g_resetn;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_insn;
    logic [31:0] cpu_rs1_data;
    logic        cpu_wb_valid;
    logic        cpu_wb_ready;
    logic        cpu_wb_wen;
    logic [4:0]  cpu_wb_addr;
    logic [31:0] cpu_wb_data;
    logic [2:0]  cpu_wb_result;
    logic        cpu_wb_timeout;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;

    scarv_cpu_cop_dispatch #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_insn(cpu_insn), .cpu_rs1_data(cpu_rs1_data),
        .cpu_wb_valid(cpu_wb_valid), .cpu_wb_ready(cpu_wb_ready),
        .cpu_wb_wen(cpu_wb_wen), .cpu_wb_addr(cpu_wb_addr),
        .cpu_wb_data(cpu_wb_data), .cpu_wb_result(cpu_wb_result),
        .cpu_wb_timeout(cpu_wb_timeout),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp),
        .cpu_insn_ack(cpu_insn_ack)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Cycle numbers are relative to the accept cycle (0); 0 for ack/rsp means never.
    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        int          ack_cyc;
        int          rsp_cyc;
        int          ready_cyc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  result;
    } stim_t;

    typedef struct {
        int          wb_cyc;
        bit          timeout;
        bit          drain;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  result;
    } expect_t;

    typedef struct {
        stim_t   s;
        expect_t e;
    } vector_t;

    int tests_run;
    int tests_failed;

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int txn, input int cyc,
                               input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s txn %0d cycle %0d: got %0h expected %0h",
                     name, txn, cyc, actual, expected);
        end
    endtask

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic vector_t mkVec(
        input logic [31:0] insn, input logic [31:0] rs1,
        input int ack, input int rsp, input int rdy,
        input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
        input logic [2:0] res,
        input int wb, input bit to, input bit dr,
        input logic ewen, input logic [4:0] eaddr, input logic [31:0] edata,
        input logic [2:0] eres);
        vector_t v;
        v.s.insn = insn;    v.s.rs1 = rs1;
        v.s.ack_cyc = ack;  v.s.rsp_cyc = rsp;  v.s.ready_cyc = rdy;
        v.s.wen = wen;      v.s.waddr = waddr;  v.s.wdata = wdata;  v.s.result = res;
        v.e.wb_cyc = wb;    v.e.timeout = to;   v.e.drain = dr;
        v.e.wen = ewen;     v.e.addr = eaddr;   v.e.data = edata;   v.e.result = eres;
        return v;
    endfunction

    // Transaction-level model: a shared budget of T cycles from the first ISSUE
    // cycle, except that an ack on the last budgeted cycle still gets one WAIT cycle.
    function automatic expect_t refModel(input stim_t s);
        expect_t e;
        int      deadline;
        e.timeout = 1'b1;  e.drain = 1'b0;  e.wen = 1'b0;
        e.addr = 5'd0;     e.data = 32'd0;  e.result = 3'b111;
        e.wb_cyc = T + 1;
        if (s.ack_cyc >= 1 && s.ack_cyc <= T) begin
            deadline = maxi(T, s.ack_cyc + 1);
            if (s.rsp_cyc > s.ack_cyc && s.rsp_cyc <= deadline) begin
                e.timeout = 1'b0;
                e.wb_cyc  = s.rsp_cyc + 1;
                e.wen     = s.wen && (s.waddr != 5'd0);
                e.addr    = s.waddr;
                e.data    = s.wdata;
                e.result  = s.result;
            end else begin
                e.drain  = 1'b1;
                e.wb_cyc = deadline + 1;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input vector_t v, input int idx);
        int h, e_cyc, issue_end, wait_lo, wait_hi, drain_lo, drain_hi;
        bit in_wb;
        h = maxi(v.e.wb_cyc, v.s.ready_cyc);
        if (v.e.timeout && !v.e.drain) begin
            issue_end = v.e.wb_cyc - 1;  wait_lo = 1;  wait_hi = 0;
        end else begin
            issue_end = v.s.ack_cyc;  wait_lo = v.s.ack_cyc + 1;  wait_hi = v.e.wb_cyc - 1;
        end
        if (v.e.drain) begin
            drain_lo = h + 1;  drain_hi = v.s.rsp_cyc;  e_cyc = v.s.rsp_cyc + 1;
        end else begin
            drain_lo = 1;  drain_hi = 0;  e_cyc = h + 1;
        end
        for (int c = 0; c < e_cyc; c++) begin
            if (c == 0) begin
                cpu_valid = 1'b1;  cpu_insn = v.s.insn;  cpu_rs1_data = v.s.rs1;
            end else begin
                cpu_valid = 1'($urandom_range(0, 1));
                cpu_insn = $urandom;  cpu_rs1_data = $urandom;
            end
            cop_insn_ack = (c > 0) && (c == v.s.ack_cyc);
            cop_insn_rsp = (c > 0) && (c == v.s.rsp_cyc);
            if (cop_insn_rsp) begin
                cop_wen = v.s.wen;  cop_waddr = v.s.waddr;
                cop_wdata = v.s.wdata;  cop_result = v.s.result;
            end else begin
                cop_wen = 1'($urandom);  cop_waddr = 5'($urandom);
                cop_wdata = $urandom;  cop_result = 3'($urandom);
            end
            cpu_wb_ready = (c > 0) && (c >= v.s.ready_cyc);
            in_wb = (c >= v.e.wb_cyc) && (c <= h);

            checkOutput("cpu_ready", idx, c, 32'(cpu_ready), 32'(c == 0));
            checkOutput("insn_req", idx, c, 32'(cpu_insn_req), 32'(c >= 1 && c <= issue_end));
            checkOutput("insn_ack", idx, c, 32'(cpu_insn_ack),
                        32'((c >= wait_lo && c <= wait_hi) || (c >= drain_lo && c <= drain_hi)));
            checkOutput("wb_valid", idx, c, 32'(cpu_wb_valid), 32'(in_wb));
            if (c >= 1 && c <= issue_end) begin
                checkOutput("insn_enc", idx, c, cpu_insn_enc, v.s.insn);
                checkOutput("rs1", idx, c, cpu_rs1, v.s.rs1);
            end
            if (in_wb) begin
                checkOutput("wb_timeout", idx, c, 32'(cpu_wb_timeout), 32'(v.e.timeout));
                checkOutput("wb_wen", idx, c, 32'(cpu_wb_wen), 32'(v.e.wen));
                checkOutput("wb_data", idx, c, cpu_wb_data, v.e.data);
                checkOutput("wb_result", idx, c, 32'(cpu_wb_result), 32'(v.e.result));
                if (!v.e.timeout) checkOutput("wb_addr", idx, c, 32'(cpu_wb_addr), 32'(v.e.addr));
            end
            step();
        end
        cpu_valid = 1'b0;  cop_insn_ack = 1'b0;  cop_insn_rsp = 1'b0;  cpu_wb_ready = 1'b0;
    endtask

    task automatic idleGap(input int n, input int idx);
        for (int i = 0; i < n; i++) begin
            checkOutput("idle_ready", idx, i, 32'(cpu_ready), 32'd1);
            checkOutput("idle_req", idx, i, 32'(cpu_insn_req), 32'd0);
            checkOutput("idle_wb_valid", idx, i, 32'(cpu_wb_valid), 32'd0);
            step();
        end
    endtask

    vector_t vectors[10];
    vector_t rv;

    initial begin
        tests_run = 0;  tests_failed = 0;
        g_resetn = 1'b0;  cpu_valid = 1'b0;  cpu_insn = '0;  cpu_rs1_data = '0;
        cpu_wb_ready = 1'b0;  cop_insn_ack = 1'b0;  cop_wen = 1'b0;  cop_waddr = '0;
        cop_wdata = '0;  cop_result = '0;  cop_insn_rsp = 1'b0;

        vectors[0] = mkVec(32'h0000_100B, 32'h1234_5678, 1, 2, 0, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0,
                           3, 0, 0, 1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0);
        vectors[1] = mkVec(32'h0040_208B, 32'hA5A5_0F0F, 10, 14, 20, 1'b1, 5'd12, 32'hCAFE_F00D, 3'd2,
                           15, 0, 0, 1'b1, 5'd12, 32'hCAFE_F00D, 3'd2);
        vectors[2] = mkVec(32'h0000_000B, 32'h0000_0001, 1, 2, 0, 1'b1, 5'd0, 32'hFFFF_FFFF, 3'd1,
                           3, 0, 0, 1'b0, 5'd0, 32'hFFFF_FFFF, 3'd1);
        vectors[3] = mkVec(32'h0000_300B, 32'h0000_0002, 0, 3, 0, 1'b1, 5'd9, 32'h1111_1111, 3'd5,
                           17, 1, 0, 1'b0, 5'd0, 32'h0, 3'b111);
        vectors[4] = mkVec(32'h0000_400B, 32'h0000_0003, 1, 21, 0, 1'b1, 5'd7, 32'h0000_0055, 3'd0,
                           17, 1, 1, 1'b0, 5'd0, 32'h0, 3'b111);
        vectors[5] = mkVec(32'h0000_500B, 32'h0000_0004, 2, 5, 0, 1'b1, 5'd31, 32'h0BAD_C0DE, 3'd0,
                           6, 0, 0, 1'b1, 5'd31, 32'h0BAD_C0DE, 3'd0);
        vectors[6] = mkVec(32'h0000_600B, 32'h0000_0005, 16, 17, 0, 1'b1, 5'd3, 32'h1357_9BDF, 3'd4,
                           18, 0, 0, 1'b1, 5'd3, 32'h1357_9BDF, 3'd4);
        vectors[7] = mkVec(32'h0000_700B, 32'h0000_0006, 16, 20, 0, 1'b1, 5'd4, 32'h2468_ACE0, 3'd6,
                           18, 1, 1, 1'b0, 5'd0, 32'h0, 3'b111);
        vectors[8] = mkVec(32'h0000_800B, 32'h0000_0007, 3, 16, 3, 1'b0, 5'd8, 32'h7777_0000, 3'd3,
                           17, 0, 0, 1'b0, 5'd8, 32'h7777_0000, 3'd3);
        vectors[9] = mkVec(32'h0000_900B, 32'h0000_0008, 4, 25, 22, 1'b1, 5'd2, 32'h9999_9999, 3'd0,
                           17, 1, 1, 1'b0, 5'd0, 32'h0, 3'b111);

        repeat (3) step();
        checkOutput("rst_ready", -1, 0, 32'(cpu_ready), 32'd0);
        checkOutput("rst_req", -1, 0, 32'(cpu_insn_req), 32'd0);
        checkOutput("rst_ack", -1, 0, 32'(cpu_insn_ack), 32'd0);
        checkOutput("rst_wb_valid", -1, 0, 32'(cpu_wb_valid), 32'd0);
        checkOutput("rst_wb_fields", -1, 0,
                    {cpu_wb_data[31:10] | 22'(cpu_wb_addr), 1'b0, cpu_wb_wen, cpu_wb_timeout,
                     cpu_wb_result, 4'd0}, 32'd0);
        checkOutput("rst_enc", -1, 0, cpu_insn_enc | cpu_rs1, 32'd0);
        g_resetn = 1'b1;
        #1;
        checkOutput("rst_ready_rise", -1, 0, 32'(cpu_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i], i);
            idleGap(i % 3, i);
        end

        for (int i = 0; i < 40; i++) begin
            int r;
            rv.s.insn = $urandom;  rv.s.rs1 = $urandom;
            rv.s.wen = 1'($urandom);  rv.s.waddr = 5'($urandom);
            rv.s.wdata = $urandom;  rv.s.result = 3'($urandom);
            r = int'($urandom_range(0, 9));
            if (r == 0)      rv.s.ack_cyc = 0;
            else if (r == 1) rv.s.ack_cyc = T + int'($urandom_range(1, 3));
            else             rv.s.ack_cyc = int'($urandom_range(1, T));
            if (rv.s.ack_cyc >= 1 && rv.s.ack_cyc <= T)
                rv.s.rsp_cyc = rv.s.ack_cyc + int'($urandom_range(1, 8));
            else
                rv.s.rsp_cyc = int'($urandom_range(0, T));
            rv.s.ready_cyc = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, T + 6));
            rv.e = refModel(rv.s);
            if (rv.e.drain && rv.s.rsp_cyc <= maxi(rv.e.wb_cyc, rv.s.ready_cyc)) begin
                rv.s.rsp_cyc = maxi(rv.e.wb_cyc, rv.s.ready_cyc) + int'($urandom_range(1, 3));
                rv.e = refModel(rv.s);
            end
            applyStimulus(rv, 100 + i);
            idleGap(int'($urandom_range(0, 2)), 100 + i);
        end

        // Reset while waiting on the COP response.
        cpu_valid = 1'b1;  cpu_insn = 32'h0000_A00B;  cpu_rs1_data = 32'h0000_00AA;
        checkOutput("mid_accept_ready", 200, 0, 32'(cpu_ready), 32'd1);
        step();
        cpu_valid = 1'b0;  cop_insn_ack = 1'b1;
        checkOutput("mid_issue_req", 200, 1, 32'(cpu_insn_req), 32'd1);
        step();
        cop_insn_ack = 1'b0;
        checkOutput("mid_wait_ack", 200, 2, 32'(cpu_insn_ack), 32'd1);
        g_resetn = 1'b0;
        step();
        checkOutput("mid_rst_req", 200, 3, 32'(cpu_insn_req), 32'd0);
        checkOutput("mid_rst_ack", 200, 3, 32'(cpu_insn_ack), 32'd0);
        checkOutput("mid_rst_wb_valid", 200, 3, 32'(cpu_wb_valid), 32'd0);
        checkOutput("mid_rst_ready", 200, 3, 32'(cpu_ready), 32'd0);
        checkOutput("mid_rst_enc", 200, 3, cpu_insn_enc, 32'd0);
        g_resetn = 1'b1;
        #1;
        checkOutput("mid_rst_ready_rise", 200, 3, 32'(cpu_ready), 32'd1);
        applyStimulus(vectors[0], 201);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
